uart_word_ctrl: RTL and testbench
=================================

# uart_word_ctrl

Word-level sequencer for the byte-wide UART datapath. It accepts 32-bit words from the user side, splits each into four bytes, and hands them one at a time to the byte transmitter with a start/busy handshake and a programmable inter-byte gap. On the receive side it assembles four received bytes into a 32-bit word, accumulates parity errors across the four bytes, and discards partial words on timeout. It sits between the application logic and the byte-level UART TX/RX cores.

## Interface
- GAP_CYCLES, 16: idle cycles inserted after the byte TX drops busy, before the next byte starts; 0 means no gap.
- TIMEOUT_CYCLES, 100000: maximum cycles allowed between consecutive RX bytes of one word; minimum 1.
- CLK  in  1  system clock; all state changes on its rising edge.
- CLR  in  1  reset, asynchronous, active-low.
- word_valid  in  1  a TX word is offered.
- word_data  in  32  the TX word; sampled on acceptance.
- word_ready  out  1  high only in TX state IDLE; acceptance is `word_valid & word_ready` at a rising edge.
- tx_byte  out  8  byte presented to the byte TX; held stable from its start pulse until the next start pulse.
- tx_start  out  1  one-cycle pulse requesting the byte TX to send tx_byte.
- tx_busy  in  1  byte TX busy flag.
- tx_done  out  1  one-cycle pulse after the 4th byte's gap completes.
- rx_byte  in  8  received byte, valid with rx_valid.
- rx_valid  in  1  one-cycle pulse per received byte.
- rx_parity_err  in  1  parity error for the byte; sampled only with rx_valid.
- rx_word  out  32  last assembled word; holds until the next complete word.
- rx_word_valid  out  1  one-cycle pulse when rx_word updates.
- rx_word_err  out  1  OR of the 4 byte parity errors; updates together with rx_word.
- rx_timeout  out  1  one-cycle pulse when a partial word is discarded.

## Operation
- Byte order is MSB first, both directions. Word 32'hAABBCCDD is sent and received as AA, BB, CC, DD.
- TX FSM states: IDLE, SEND, WAIT_HI, WAIT_LO, GAP.
  - IDLE: on acceptance, latch word_data, set byte_idx=0, go to SEND.
  - SEND: tx_start=1 for exactly this cycle; tx_byte = word[31-8*byte_idx -: 8], registered so it is valid in the same cycle; go to WAIT_HI.
  - WAIT_HI: stay until tx_busy=1, then go to WAIT_LO. There is no timeout.
  - WAIT_LO: stay until tx_busy=0. Then go to GAP if GAP_CYCLES>0; otherwise apply the GAP exit action directly.
  - GAP: count GAP_CYCLES cycles. At exit: if byte_idx==3, pulse tx_done and go to IDLE; else increment byte_idx and go to SEND.
  - A word_valid arriving outside IDLE is not accepted; it is held off by word_ready=0.
- RX path: 2-bit byte count, 24-bit shift register, error accumulator, timeout counter.
  - On rx_valid with count<3: shift[23:0] = {shift[15:0], rx_byte}; err_acc |= rx_parity_err; count++; timeout counter cleared.
  - On rx_valid with count==3: rx_word <= {shift, rx_byte}; rx_word_err <= err_acc | rx_parity_err; pulse rx_word_valid; clear count and err_acc.
  - When count!=0 and no rx_valid arrives, the timeout counter increments. When it reaches TIMEOUT_CYCLES: pulse rx_timeout, clear count, err_acc and counter. rx_word and rx_word_err are unchanged.
  - When count==0, the timeout counter is held at 0.
- TX and RX paths are fully independent; loopback (Rx tied to Tx) is a supported use case.

## Timing
- Reset values: word_ready=1 (TX in IDLE), tx_start=0, tx_byte=8'h00, tx_done=0, rx_word=32'h0, rx_word_valid=0, rx_word_err=0, rx_timeout=0. Internal counts are 0.
- Reset asserted mid-operation aborts everything immediately, asynchronously. A partial TX word is not resumed and a partial RX word is lost.
- TX latency: tx_start is high in the cycle after acceptance. The next byte's tx_start comes GAP_CYCLES+1 cycles after the first cycle tx_busy is sampled low in WAIT_LO. tx_done fires in the same cycle the FSM re-enters IDLE, so word_ready is high in the cycle after tx_done.
- RX latency: rx_word and rx_word_valid update in the cycle after the 4th rx_valid edge, i.e. they are registered.
- Simultaneous rx_valid and timeout expiry in the same cycle: the byte wins. It is accepted as a continuation and no rx_timeout is issued.
- Back-to-back rx_valid on consecutive cycles is supported.
- Counter widths are sized by $clog2 of the parameters; they must not wrap before their terminal counts.

## Test plan
- TX single word, GAP_CYCLES=16, byte TX model busy for 100 cycles: word_data=32'hABACADAE.
  - tx_byte sequence is AB, AC, AD, AE with 4 tx_start pulses.
  - Gap between tx_busy fall and the next tx_start is 17 cycles.
  - One tx_done pulse, then word_ready=1.
- Loopback through the byte UART cores, Data word incrementing from 32'hABACADAE for 3 words:
  - rx_word = ABACADAE, ABACADAF, ABACADB0.
  - rx_word_err=0 and one rx_word_valid per word.
- RX parity: inject rx_parity_err=1 on the 2nd of 4 bytes 11,22,33,44.
  - rx_word=32'h11223344, rx_word_err=1.
  - The next clean word gives rx_word_err=0.
- RX timeout, TIMEOUT_CYCLES=50: send 2 bytes, then wait 50 cycles.
  - rx_timeout pulses once; rx_word is unchanged.
  - The following 4 bytes 55,66,77,88 yield 32'h55667788.
  - Also apply rx_valid exactly on the expiry cycle: no timeout, and the byte is counted.
- Reset mid-word: assert CLR low while the TX FSM is in WAIT_LO on byte 2 and the RX count is 3.
  - All outputs go to their reset values immediately.
  - After release, a new word transmits from its MSB byte and RX assembly restarts from count 0.
- Hold-off: keep word_valid high continuously with a new word_data each acceptance.
  - Exactly one acceptance per tx_done, and no acceptance while word_ready=0.

Source files
------------

// File: rtl/uart_word_ctrl.sv
// Word-level sequencer between application logic and byte-wide UART cores.
// TX splits 32-bit words into four MSB-first bytes; RX reassembles them, with a partial-word timeout.
module uart_word_ctrl #(
    parameter int GAP_CYCLES     = 16,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic        CLK,
    input  logic        CLR,
    input  logic        word_valid,
    input  logic [31:0] word_data,
    output logic        word_ready,
    output logic [7:0]  tx_byte,
    output logic        tx_start,
    input  logic        tx_busy,
    output logic        tx_done,
    input  logic [7:0]  rx_byte,
    input  logic        rx_valid,
    input  logic        rx_parity_err,
    output logic [31:0] rx_word,
    output logic        rx_word_valid,
    output logic        rx_word_err,
    output logic        rx_timeout
);

    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_SEND, S_WAIT_HI, S_WAIT_LO, S_GAP
    } tx_state_t;

    tx_state_t       state_reg, state_next, exit_state;
    logic [23:0]     word_sh_reg;
    logic [1:0]      byte_idx_reg;
    logic [GW-1:0]   gap_cnt_reg;
    logic [7:0]      tx_byte_reg;

    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            state_reg    <= S_IDLE;
            word_sh_reg  <= '0;
            byte_idx_reg <= '0;
            gap_cnt_reg  <= '0;
            tx_byte_reg  <= '0;
        end else begin
            state_reg <= state_next;
            // tx_byte is loaded on the edge into SEND so it is already valid alongside tx_start
            if (state_reg == S_IDLE && word_valid) begin
                word_sh_reg  <= word_data[23:0];
                tx_byte_reg  <= word_data[31:24];
                byte_idx_reg <= 2'd0;
            end else if (state_reg != S_IDLE && state_next == S_SEND) begin
                word_sh_reg  <= {word_sh_reg[15:0], 8'h00};
                tx_byte_reg  <= word_sh_reg[23:16];
                byte_idx_reg <= byte_idx_reg + 2'd1;
            end
            gap_cnt_reg <= (state_reg == S_GAP) ? gap_cnt_reg + GW'(1) : '0;
        end
    end

    always_comb begin
        state_next = state_reg;
        exit_state = (byte_idx_reg == 2'd3) ? S_IDLE : S_SEND;
        unique case (state_reg)
            S_IDLE:    if (word_valid) state_next = S_SEND;
            S_SEND:    state_next = S_WAIT_HI;
            S_WAIT_HI: if (tx_busy) state_next = S_WAIT_LO;
            S_WAIT_LO: if (!tx_busy) state_next = (GAP_CYCLES > 0) ? S_GAP : exit_state;
            S_GAP:     if (gap_cnt_reg == GAP_LAST) state_next = exit_state;
            default:   state_next = S_IDLE;
        endcase
    end

    always_comb begin
        word_ready = (state_reg == S_IDLE);
        tx_start   = (state_reg == S_SEND);
        tx_done    = (state_reg != S_IDLE) && (state_next == S_IDLE);
    end

    assign tx_byte = tx_byte_reg;

    logic [1:0]      rx_cnt_reg;
    logic [23:0]     rx_sh_reg;
    logic            err_acc_reg;
    logic [TW-1:0]   to_cnt_reg;
    logic [31:0]     rx_word_reg;
    logic            rx_word_valid_reg, rx_word_err_reg, rx_timeout_reg;

    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            rx_cnt_reg        <= '0;
            rx_sh_reg         <= '0;
            err_acc_reg       <= 1'b0;
            to_cnt_reg        <= '0;
            rx_word_reg       <= '0;
            rx_word_valid_reg <= 1'b0;
            rx_word_err_reg   <= 1'b0;
            rx_timeout_reg    <= 1'b0;
        end else begin
            rx_word_valid_reg <= 1'b0;
            rx_timeout_reg    <= 1'b0;
            // An arriving byte takes priority over a timeout expiring in the same cycle
            if (rx_valid) begin
                to_cnt_reg <= '0;
                if (rx_cnt_reg == 2'd3) begin
                    rx_word_reg       <= {rx_sh_reg, rx_byte};
                    rx_word_err_reg   <= err_acc_reg | rx_parity_err;
                    rx_word_valid_reg <= 1'b1;
                    rx_cnt_reg        <= 2'd0;
                    err_acc_reg       <= 1'b0;
                end else begin
                    rx_sh_reg   <= {rx_sh_reg[15:0], rx_byte};
                    err_acc_reg <= err_acc_reg | rx_parity_err;
                    rx_cnt_reg  <= rx_cnt_reg + 2'd1;
                end
            end else if (rx_cnt_reg != 2'd0) begin
                if (to_cnt_reg == TO_LAST) begin
                    rx_timeout_reg <= 1'b1;
                    rx_cnt_reg     <= 2'd0;
                    err_acc_reg    <= 1'b0;
                    to_cnt_reg     <= '0;
                end else begin
                    to_cnt_reg <= to_cnt_reg + TW'(1);
                end
            end
        end
    end

    assign rx_word       = rx_word_reg;
    assign rx_word_valid = rx_word_valid_reg;
    assign rx_word_err   = rx_word_err_reg;
    assign rx_timeout    = rx_timeout_reg;

endmodule

// File: tb/tb_uart_word_ctrl.sv
// Randomized bench for uart_word_ctrl: a byte-TX model with optional loopback drives the DUT,
// and word-level reference models (byte queues, idle counter) check every cycle at the falling edge.
module tb_uart_word_ctrl;
    localparam int GAP = 16;
    localparam int TMO = 50;

    logic        CLK = 1'b0;
    logic        CLR = 1'b0;
    logic        word_valid = 1'b0;
    logic [31:0] word_data = '0;
    logic        word_ready;
    logic [7:0]  tx_byte;
    logic        tx_start;
    logic        tx_busy = 1'b0;
    logic        tx_done;
    logic [7:0]  rx_byte;
    logic        rx_valid;
    logic        rx_parity_err;
    logic [31:0] rx_word;
    logic        rx_word_valid, rx_word_err, rx_timeout;

    logic        man_valid = 1'b0, man_err = 1'b0, lb_valid = 1'b0;
    logic [7:0]  man_byte = '0, lb_byte = '0;
    assign rx_valid      = man_valid | lb_valid;
    assign rx_byte       = lb_valid ? lb_byte : man_byte;
    assign rx_parity_err = man_valid & man_err;

    uart_word_ctrl #(.GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TMO)) dut (
        .CLK(CLK), .CLR(CLR),
        .word_valid(word_valid), .word_data(word_data), .word_ready(word_ready),
        .tx_byte(tx_byte), .tx_start(tx_start), .tx_busy(tx_busy), .tx_done(tx_done),
        .rx_byte(rx_byte), .rx_valid(rx_valid), .rx_parity_err(rx_parity_err),
        .rx_word(rx_word), .rx_word_valid(rx_word_valid), .rx_word_err(rx_word_err),
        .rx_timeout(rx_timeout)
    );

    always #5 CLK = ~CLK;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // ---------------- reference models, evaluated at the falling edge ----------------
    int          cyc = 0;
    logic [7:0]  tx_exp[$];
    bit          in_flight = 0;
    int          accepts = 0, dones = 0, starts = 0;
    int          fall_cyc = -1000;
    bit          prev_busy = 0;
    logic [7:0]  held_byte = '0;

    logic [7:0]  rx_q[$];
    bit          rx_err_acc = 0;
    int          idle = 0;
    logic [31:0] m_word = '0;
    bit          m_err = 0, exp_wv = 0, exp_to = 0;
    int          wv_cnt = 0, to_cnt = 0;

    always @(negedge CLK) begin
        cyc++;
        if (!CLR) begin
            check("rst_word_ready", word_ready, 1);
            check("rst_tx_start", tx_start, 0);
            check("rst_tx_byte", tx_byte, 0);
            check("rst_tx_done", tx_done, 0);
            check("rst_rx_word", rx_word, 0);
            check("rst_rx_word_valid", rx_word_valid, 0);
            check("rst_rx_word_err", rx_word_err, 0);
            check("rst_rx_timeout", rx_timeout, 0);
            tx_exp.delete(); in_flight = 0; held_byte = '0; fall_cyc = -1000;
            rx_q.delete(); rx_err_acc = 0; idle = 0; m_word = '0; m_err = 0;
            exp_wv = 0; exp_to = 0;
        end else begin
            check("rx_word_valid", rx_word_valid, exp_wv);
            check("rx_timeout", rx_timeout, exp_to);
            check("rx_word", rx_word, m_word);
            check("rx_word_err", rx_word_err, m_err);
            if (rx_word_valid) wv_cnt++;
            if (rx_timeout) to_cnt++;
            exp_wv = 0; exp_to = 0;
            if (rx_valid) begin
                rx_q.push_back(rx_byte);
                rx_err_acc |= rx_parity_err;
                idle = 0;
                if (rx_q.size() == 4) begin
                    m_word = {rx_q[0], rx_q[1], rx_q[2], rx_q[3]};
                    m_err = rx_err_acc; exp_wv = 1;
                    rx_q.delete(); rx_err_acc = 0;
                end
            end else if (rx_q.size() != 0) begin
                idle++;
                if (idle == TMO) begin
                    exp_to = 1; rx_q.delete(); rx_err_acc = 0; idle = 0;
                end
            end

            check("word_ready", word_ready, !in_flight);
            if (prev_busy && !tx_busy) fall_cyc = cyc;
            if (tx_start) begin
                starts++;
                check("tx_start_expected", tx_exp.size() != 0, 1);
                if (tx_exp.size() != 0) begin
                    if (tx_exp.size() < 4) check("tx_gap", cyc - fall_cyc, GAP + 1);
                    held_byte = tx_exp.pop_front();
                    check("tx_byte", tx_byte, held_byte);
                end
            end else begin
                check("tx_byte_hold", tx_byte, held_byte);
            end
            if (tx_done) begin
                dones++;
                check("tx_done_gap", cyc - fall_cyc, GAP);
                check("tx_done_bytes_left", tx_exp.size(), 0);
                check("tx_done_in_flight", in_flight, 1);
                in_flight = 0;
            end
            if (word_valid && word_ready) begin
                accepts++;
                for (int i = 3; i >= 0; i--) tx_exp.push_back(word_data[8*i +: 8]);
                in_flight = 1;
            end
        end
        prev_busy = tx_busy;
    end

    // ---------------- byte transmitter model with optional loopback ----------------
    int         busy_len = 100;
    bit         loop_en = 0;
    bit         model_busy = 0;
    logic [7:0] model_b = '0;

    initial forever begin
        @(negedge CLK);
        if (CLR && tx_start) begin
            model_b = tx_byte;
            model_busy = 1;
            @(posedge CLK); #1 tx_busy = 1'b1;
            repeat (busy_len) @(posedge CLK);
            #1 tx_busy = 1'b0;
            if (loop_en) begin
                lb_byte = model_b; lb_valid = 1'b1;
                @(posedge CLK); #1 lb_valid = 1'b0;
            end
            model_busy = 0;
        end
    end

    // ---------------- stimulus helpers (called at posedge+1) ----------------
    task automatic tick();
        @(posedge CLK); #1;
    endtask

    task automatic rx_send(input logic [7:0] b, input logic e);
        man_byte = b; man_err = e; man_valid = 1'b1;
        tick();
        man_valid = 1'b0; man_err = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        int k = 0;
        while (!word_ready && k < 5000) begin tick(); k++; end
        check("send_word_ready_bound", k < 5000, 1);
        word_valid = 1'b1; word_data = w;
        tick();
        word_valid = 1'b0;
    endtask

    task automatic wait_done(input int n);
        int k = 0;
        while (dones < n && k < 20000) begin tick(); k++; end
        check("tx_done_bound", dones >= n, 1);
    endtask

    task automatic wait_model_idle();
        int k = 0;
        while (model_busy && k < 5000) begin tick(); k++; end
        check("byte_model_idle_bound", model_busy, 0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [31:0] w, w_before;
    logic [7:0]  b0, b1, b2, b3;
    int s0, d0, a0, k;

    initial begin
        repeat (3) tick();
        CLR = 1'b1;
        tick();

        // single word, long busy
        busy_len = 100;
        send_word(32'hABACADAE);
        wait_done(1);
        tick();
        check("t1_starts", starts, 4);
        check("t1_dones", dones, 1);
        check("t1_ready_after_done", word_ready, 1);

        // loopback of three incrementing words
        loop_en = 1; busy_len = 8; s0 = wv_cnt;
        for (int i = 0; i < 3; i++) send_word(32'hABACADAE + 32'(i));
        wait_done(4);
        repeat (5) tick();
        check("lb_word_count", wv_cnt - s0, 3);
        check("lb_last_word", rx_word, 32'hABACADB0);
        check("lb_last_err", rx_word_err, 0);
        loop_en = 0;

        // parity error on the second byte, then a clean word
        rx_send(8'h11, 0); rx_send(8'h22, 1); rx_send(8'h33, 0); rx_send(8'h44, 0);
        check("par_word", rx_word, 32'h11223344);
        check("par_err", rx_word_err, 1);
        check("par_valid", rx_word_valid, 1);
        w = $urandom;
        for (int i = 3; i >= 0; i--) rx_send(w[8*i +: 8], 0);
        check("clean_word", rx_word, w);
        check("clean_err", rx_word_err, 0);

        // timeout after two bytes
        s0 = to_cnt; w_before = rx_word;
        rx_send(8'hE1, 0); rx_send(8'hE2, 1);
        repeat (TMO) tick();
        check("to_pulse", rx_timeout, 1);
        check("to_word_kept", rx_word, w_before);
        tick();
        check("to_count", to_cnt - s0, 1);
        rx_send(8'h55, 0); rx_send(8'h66, 0); rx_send(8'h77, 0); rx_send(8'h88, 0);
        check("after_to_word", rx_word, 32'h55667788);
        check("after_to_err", rx_word_err, 0);

        // byte arriving exactly on the expiry cycle continues the word
        s0 = to_cnt;
        rx_send(8'hC1, 0); rx_send(8'hC2, 0);
        repeat (TMO - 1) tick();
        rx_send(8'hC3, 0);
        check("expiry_no_timeout", rx_timeout, 0);
        rx_send(8'hC4, 0);
        check("expiry_word", rx_word, 32'hC1C2C3C4);
        check("expiry_to_count", to_cnt - s0, 0);

        // randomized RX traffic with gaps around the timeout boundary
        for (int i = 0; i < 60; i++) begin
            int g;
            case ($urandom_range(0, 3))
                0: g = 0;
                1: g = $urandom_range(1, 10);
                2: g = TMO - 1;
                default: g = TMO + $urandom_range(0, 3);
            endcase
            repeat (g) tick();
            rx_send(8'($urandom), ($urandom_range(0, 3) == 0));
        end
        repeat (TMO + 5) tick();

        // reset mid-word: TX in WAIT_LO on byte 2, RX count 3
        busy_len = 30; s0 = starts; k = 0;
        send_word($urandom);
        while (!(starts >= s0 + 2 && tx_busy) && k < 5000) begin tick(); k++; end
        check("reset_setup_bound", k < 5000, 1);
        tick();
        rx_send(8'h9A, 0); rx_send(8'h9B, 1); rx_send(8'h9C, 0);
        #2 CLR = 1'b0;
        #1;
        check("async_word_ready", word_ready, 1);
        check("async_tx_start", tx_start, 0);
        check("async_tx_byte", tx_byte, 0);
        check("async_tx_done", tx_done, 0);
        check("async_rx_word", rx_word, 0);
        check("async_rx_word_valid", rx_word_valid, 0);
        check("async_rx_word_err", rx_word_err, 0);
        check("async_rx_timeout", rx_timeout, 0);
        tick();
        CLR = 1'b1;
        wait_model_idle();
        tick();
        busy_len = 5; d0 = dones; s0 = starts;
        w = $urandom;
        send_word(w);
        wait_done(d0 + 1);
        check("post_reset_starts", starts - s0, 4);
        {b0, b1, b2, b3} = $urandom;
        rx_send(b0, 0); rx_send(b1, 0); rx_send(b2, 0); rx_send(b3, 0);
        check("post_reset_rx_word", rx_word, {b0, b1, b2, b3});
        check("post_reset_rx_err", rx_word_err, 0);

        // hold-off: word_valid held high, new data after each acceptance
        wait_model_idle();
        busy_len = 3; a0 = accepts; d0 = dones; k = 0;
        @(posedge CLK); #1;
        word_valid = 1'b1; word_data = $urandom;
        while (dones - d0 < 5 && k < 20000) begin
            @(negedge CLK); #1;
            k++;
            if (word_valid && word_ready) begin
                @(posedge CLK); #1 word_data = $urandom;
            end
        end
        @(posedge CLK); #1 word_valid = 1'b0;
        check("holdoff_bound", k < 20000, 1);
        wait_model_idle();
        repeat (3) tick();
        check("holdoff_accepts", accepts - a0, 5);
        check("holdoff_dones", dones - d0, 5);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
